systolic_sequencer: RTL and testbench
=====================================

# systolic_sequencer

Job controller for the N x N weight-stationary PE array. It buffers one N x N weight tile and shifts it into the columns so every PE latches its weight on a single cycle. It then streams activation vectors into the west edge with per-row skew, driving the valid and switch flags. Bottom-row partial sums are deskewed into one N-lane result vector per input vector. It sits between the host/DMA streams and the array, and is the only driver of the array's control edges.

## Interface
Parameters:
- N, 4, array rows = columns
- MAX_VEC, 256, maximum activation vectors per job
- CW, $clog2(MAX_VEC+1), width of vector count

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_start  in  1  start-job pulse; sampled only in IDLE
- cfg_mode  in  2  sys_mode for the job (00 Q8.8, 01 INT16, 10 INT8x2, 11 INT4x4)
- cfg_num_vec  in  CW  activation vectors in the job
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at job end
- w_valid / w_ready  in / out  1 / 1  weight-row stream handshake
- w_data  in  N*16  one weight row per beat; first beat is row 0; lane c goes to column c
- a_valid / a_ready  in / out  1 / 1  activation stream handshake
- a_data  in  N*16  one vector per beat; lane r goes to row r
- arr_weight  out  N*16  top-edge pe_weight_in per column
- arr_accept_w  out  N  pe_accept_w_in per row
- arr_input  out  N*16  west-edge pe_input_in per row
- arr_valid  out  N  west-edge pe_valid_in per row
- arr_switch  out  N  west-edge pe_switch_in per row
- arr_enabled  out  1  pe_enabled to all PEs
- arr_mode  out  2  sys_mode to all PEs
- arr_psum  in  N*32  bottom-row pe_psum_out per column; the top-row psum_in is tied to 0 outside this block
- arr_psum_valid  in  N  bottom-row pe_valid_out per column
- res_valid  out  1  result vector valid; no backpressure, so the sink accepts every cycle
- res_data  out  N*32  lane c holds the column c dot product

## Operation
- All outputs are registered. Reset value of every output is 0.
- Rst at any time forces IDLE, zeroes all outputs and counters, and discards buffered weights. Rst takes priority over every other input.
- IDLE:
  - arr_enabled=0, which clears PE state.
  - On cfg_start, latch cfg_mode into arr_mode (held until the next start) and latch cfg_num_vec.
  - If cfg_num_vec=0, pulse done on the next cycle and stay in IDLE.
  - Otherwise go to LOAD_W.
  - cfg_start outside IDLE is ignored.
- LOAD_W:
  - arr_enabled=1; w_ready=1.
  - Each w_valid&w_ready beat k (0..N-1) is stored into bank row k. Gaps in w_valid are allowed.
  - After the N-th beat, go to PUSH_W.
- PUSH_W (exactly N cycles, p=0..N-1, no stalls):
  - arr_weight = bank row N-1-p.
  - arr_accept_w = all ones on p=N-1 only, 0 otherwise. Row r then latches W[r].
  - Go to STREAM.
- STREAM:
  - a_ready=1 while accepted count < num_vec.
  - An accepted vector enters a per-row delay line; row r has r stages.
  - arr_valid[r] carries the delayed beat valid. Cycles without an accepted beat become bubbles (valid 0, input 0).
  - arr_switch[r] is high only alongside the first vector of the job on row r.
  - After num_vec acceptances, a_ready=0; go to DRAIN.
- DRAIN:
  - Delay lines keep shifting.
  - Count res_valid beats. When the count reaches num_vec, pulse done, drop arr_enabled and go to IDLE.
- Deskew: column c psum/valid passes N-1-c stages, then the output register. res_valid = deskewed arr_psum_valid[0]. All lanes are aligned by construction.
- No arithmetic on psum: lanes are passed as-is, 32-bit, with no saturation.
- arr_accept_w and arr_switch are never high in the same cycle.

## Timing
- Weight load: after the last w beat, PUSH_W occupies the next N cycles; the accept pulse is on the last one.
- First a_ready is on the cycle after PUSH_W ends.
- Vector accepted in cycle t:
  - it reaches row r on arr_input/arr_valid at cycle t+1+r;
  - column c returns on arr_psum at t+1+N+c;
  - res_valid/res_data appear at t+2N+1 (9 cycles for N=4).
- Back-to-back acceptances produce back-to-back results. Bubbles are preserved one-for-one.
- Done rises the cycle after the num_vec-th res_valid; busy falls the same cycle.

## Test plan
- Reset mid-STREAM at num_vec=8 after 3 acceptances: next cycle all outputs 0, busy=0, no done. A new job then runs normally.
- N=4, W = identity, num_vec=1, a=(1,2,3,4): arr_accept_w=4'b1111 for exactly one cycle. res_data=(1,2,3,4) 9 cycles after acceptance, then a done pulse.
- w_valid toggling 1-0-1-0: the bank fills correctly. PUSH_W is still N contiguous cycles with the row order N-1..0 on arr_weight.
- num_vec=5, a_valid low for 2 cycles after vector 2: 5 res_valid beats with the same gap; arr_switch pulses once per row, skewed by r.
- cfg_mode=2'b11 with W lanes all 0x1111 and a=0x1111 on every row: each res lane = 16. arr_mode holds 11 until the next start.
- cfg_num_vec=0: done one cycle after start, w_ready never high, arr_enabled stays 0. cfg_start while busy leaves arr_mode and the count unchanged.

Source files
------------

// File: rtl/systolic_sequencer.sv
// Job controller for an N x N weight-stationary PE array: buffers a weight tile, pushes it
// down the columns, streams skewed activations in and deskews bottom-row psums into result vectors.
module systolic_sequencer #(
  parameter int N       = 4,
  parameter int MAX_VEC = 256,
  parameter int CW      = $clog2(MAX_VEC + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic [1:0]      cfg_mode,
  input  logic [CW-1:0]   cfg_num_vec,
  output logic            busy,
  output logic            done,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*16-1:0] w_data,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [N*16-1:0] a_data,
  output logic [N*16-1:0] arr_weight,
  output logic [N-1:0]    arr_accept_w,
  output logic [N*16-1:0] arr_input,
  output logic [N-1:0]    arr_valid,
  output logic [N-1:0]    arr_switch,
  output logic            arr_enabled,
  output logic [1:0]      arr_mode,
  input  logic [N*32-1:0] arr_psum,
  input  logic [N-1:0]    arr_psum_valid,
  output logic            res_valid,
  output logic [N*32-1:0] res_data
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_PUSH_W, S_STREAM, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [CW-1:0]   num_q, num_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   res_cnt_q, res_cnt_d;
  logic [LW-1:0]   wcnt_q, wcnt_d;
  logic [LW-1:0]   pcnt_q, pcnt_d;
  logic            done_q, done_d;
  logic [N*16-1:0] weight_q, weight_d;
  logic [N*16-1:0] bank_q [N];
  logic [N-1:0]    accept_q;
  logic            busy_q, w_ready_q, a_ready_q, en_q;
  logic            w_fire, a_fire, first_fire;
  logic [N-1:0]    res_v_w;
  logic            res_valid_w;
  logic            unused_res_v;

  assign w_fire      = w_valid & w_ready_q;
  assign a_fire      = a_valid & a_ready_q;
  assign first_fire  = a_fire & (acc_q == '0);
  assign res_valid_w = res_v_w[0];

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    acc_d     = acc_q;
    res_cnt_d = res_cnt_q;
    wcnt_d    = wcnt_q;
    pcnt_d    = pcnt_q;
    done_d    = 1'b0;
    weight_d  = '0;
    // Results can start arriving while later vectors are still being accepted.
    if ((state_q == S_STREAM || state_q == S_DRAIN) && res_valid_w)
      res_cnt_d = res_cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          mode_d    = cfg_mode;
          num_d     = cfg_num_vec;
          acc_d     = '0;
          res_cnt_d = '0;
          wcnt_d    = '0;
          pcnt_d    = '0;
          if (cfg_num_vec == '0) done_d = 1'b1;
          else                   state_d = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_fire) begin
          wcnt_d = wcnt_q + LW'(1);
          if (wcnt_q == LW'(N - 1)) begin
            state_d = S_PUSH_W;
            pcnt_d  = '0;
          end
        end
      end
      S_PUSH_W: begin
        pcnt_d = pcnt_q + LW'(1);
        if (pcnt_q == LW'(N - 1)) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (a_fire) begin
          acc_d = acc_q + CW'(1);
          if (acc_d == num_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (res_valid_w && res_cnt_d == num_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The first pushed row (N-1) is the beat being written this cycle, so bypass the bank.
    if (state_d == S_PUSH_W)
      weight_d = (state_q == S_LOAD_W) ? w_data : bank_q[LW'(N - 1) - pcnt_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      num_q     <= '0;
      acc_q     <= '0;
      res_cnt_q <= '0;
      wcnt_q    <= '0;
      pcnt_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      w_ready_q <= 1'b0;
      a_ready_q <= 1'b0;
      en_q      <= 1'b0;
      weight_q  <= '0;
      accept_q  <= '0;
      for (int k = 0; k < N; k++) bank_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      acc_q     <= acc_d;
      res_cnt_q <= res_cnt_d;
      wcnt_q    <= wcnt_d;
      pcnt_q    <= pcnt_d;
      done_q    <= done_d;
      busy_q    <= (state_d != S_IDLE);
      w_ready_q <= (state_d == S_LOAD_W);
      a_ready_q <= (state_d == S_STREAM);
      en_q      <= (state_d != S_IDLE);
      weight_q  <= weight_d;
      accept_q  <= (state_d == S_PUSH_W && pcnt_d == LW'(N - 1)) ? '1 : '0;
      if (state_q == S_LOAD_W && w_fire) bank_q[wcnt_q] <= w_data;
    end
  end

  // West-edge skew: row gi sees each accepted beat gi cycles later than row 0.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    logic [gi:0][17:0] line_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        line_q <= '0;
      end else begin
        line_q[0] <= {first_fire, a_fire, a_fire ? a_data[gi*16 +: 16] : 16'h0000};
        for (int k = 1; k <= gi; k++) line_q[k] <= line_q[k-1];
      end
    end
    assign arr_input[gi*16 +: 16] = line_q[gi][15:0];
    assign arr_valid[gi]          = line_q[gi][16];
    assign arr_switch[gi]         = line_q[gi][17];
  end

  // South-edge deskew: column gi arrives gi cycles late, so it waits N-1-gi stages plus output.
  for (genvar gi = 0; gi < N; gi++) begin : g_col
    localparam int D = N - gi;
    logic [D-1:0][32:0] dsk_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        dsk_q <= '0;
      end else begin
        dsk_q[0] <= {arr_psum_valid[gi], arr_psum[gi*32 +: 32]};
        for (int k = 1; k < D; k++) dsk_q[k] <= dsk_q[k-1];
      end
    end
    assign res_data[gi*32 +: 32] = dsk_q[D-1][31:0];
    assign res_v_w[gi]           = dsk_q[D-1][32];
  end

  assign unused_res_v = ^res_v_w;

  assign busy         = busy_q;
  assign done         = done_q;
  assign w_ready      = w_ready_q;
  assign a_ready      = a_ready_q;
  assign arr_weight   = weight_q;
  assign arr_accept_w = accept_q;
  assign arr_enabled  = en_q;
  assign arr_mode     = mode_q;
  assign res_valid    = res_v_w[0];

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: a behavioural PE array closes the loop, a scoreboard
// queue holds hand-computed result vectors and a monitor checks them as they appear.
module tb_systolic_sequencer;
  localparam int N       = 4;
  localparam int MAX_VEC = 256;
  localparam int CW      = $clog2(MAX_VEC + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_start;
  logic [1:0]      cfg_mode;
  logic [CW-1:0]   cfg_num_vec;
  logic            busy, done;
  logic            w_valid, w_ready;
  logic [N*16-1:0] w_data;
  logic            a_valid, a_ready;
  logic [N*16-1:0] a_data;
  logic [N*16-1:0] arr_weight;
  logic [N-1:0]    arr_accept_w;
  logic [N*16-1:0] arr_input;
  logic [N-1:0]    arr_valid, arr_switch;
  logic            arr_enabled;
  logic [1:0]      arr_mode;
  logic [N*32-1:0] arr_psum;
  logic [N-1:0]    arr_psum_valid;
  logic            res_valid;
  logic [N*32-1:0] res_data;

  systolic_sequencer #(.N(N), .MAX_VEC(MAX_VEC), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_num_vec(cfg_num_vec),
    .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .arr_weight(arr_weight),
    .arr_accept_w(arr_accept_w), .arr_input(arr_input), .arr_valid(arr_valid),
    .arr_switch(arr_switch), .arr_enabled(arr_enabled), .arr_mode(arr_mode),
    .arr_psum(arr_psum), .arr_psum_valid(arr_psum_valid), .res_valid(res_valid),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural PE array ----------------
  function automatic logic [31:0] pe_mul(input logic [15:0] x, input logic [15:0] w, input logic [1:0] m);
    logic signed [15:0] xs, ws;
    logic signed [7:0]  xb, wb;
    logic signed [3:0]  xn, wn;
    logic signed [31:0] p;
    xs = x; ws = w; p = 0;
    case (m)
      2'b00: begin p = xs * ws; p = p >>> 8; end
      2'b01: p = xs * ws;
      2'b10: for (int k = 0; k < 2; k++) begin xb = x[k*8 +: 8]; wb = w[k*8 +: 8]; p = p + xb * wb; end
      default: for (int k = 0; k < 4; k++) begin xn = x[k*4 +: 4]; wn = w[k*4 +: 4]; p = p + xn * wn; end
    endcase
    return p;
  endfunction

  logic [N*16-1:0] wd_q [N];
  logic [15:0]     wl_q [N][N];
  logic [15:0]     x_q  [N][N];
  logic            xv_q [N][N];
  logic [31:0]     ps_q [N][N];
  logic [15:0]     xin;
  logic            vin;
  logic [31:0]     pin;

  always @(posedge clk) begin
    if (!arr_enabled) begin
      for (int r = 0; r < N; r++) begin
        wd_q[r] <= '0;
        for (int c = 0; c < N; c++) begin
          wl_q[r][c] <= '0; x_q[r][c] <= '0; xv_q[r][c] <= 1'b0; ps_q[r][c] <= '0;
        end
      end
    end else begin
      wd_q[0] <= arr_weight;
      for (int k = 1; k < N; k++) wd_q[k] <= wd_q[k-1];
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          xin = (c == 0) ? arr_input[r*16 +: 16] : x_q[r][c-1];
          vin = (c == 0) ? arr_valid[r] : xv_q[r][c-1];
          pin = (r == 0) ? 32'd0 : ps_q[r-1][c];
          x_q[r][c]  <= xin;
          xv_q[r][c] <= vin;
          ps_q[r][c] <= pin + pe_mul(xin, wl_q[r][c], arr_mode);
          if (arr_accept_w[r])
            wl_q[r][c] <= (r == 0) ? arr_weight[c*16 +: 16] : wd_q[r-1][c*16 +: 16];
        end
      end
    end
  end

  always_comb begin
    arr_psum       = '0;
    arr_psum_valid = '0;
    for (int c = 0; c < N; c++) begin
      arr_psum[c*32 +: 32] = ps_q[N-1][c];
      arr_psum_valid[c]    = xv_q[N-1][c];
    end
  end

  // ---------------- scoreboard and monitors ----------------
  typedef struct {
    logic [N*32-1:0] data;
    int              cyc;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;
  int   last_res_cyc = -1;

  always @(negedge clk) begin
    if (!rst && res_valid) begin
      last_res_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("res_unexpected", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("result cycle %0d data %h", cyc, res_data);
        chk("res_data", res_data, mon_e.data);
        chk("res_latency", cyc, mon_e.cyc);
      end
    end
  end

  logic [N*16-1:0] wh [N];
  logic [N*16-1:0] exp_rows [N];
  int acc_pulses = 0;
  int exp_acc = 0;
  int overlap_cnt = 0;
  int sw_cnt [N];
  int sw_cyc [N];

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = N - 1; k > 0; k--) wh[k] = wh[k-1];
      wh[0] = arr_weight;
      if (|(arr_accept_w & arr_switch)) overlap_cnt++;
      if (arr_accept_w != '0) begin
        acc_pulses++;
        chk("accept_all_rows", arr_accept_w, {N{1'b1}});
        for (int k = 0; k < N; k++) chk("push_row_order", wh[k], exp_rows[k]);
      end
      for (int r = 0; r < N; r++) if (arr_switch[r]) begin sw_cnt[r]++; sw_cyc[r] = cyc; end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  int last_acc_t;
  int first_acc_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [1:0] m, input int nv);
    cfg_start = 1'b1; cfg_mode = m; cfg_num_vec = CW'(nv);
    tick();
    cfg_start = 1'b0;
    $display("start mode %0d num_vec %0d", m, nv);
  endtask

  task automatic load_w(input logic [N*N*16-1:0] wt, input bit gaps);
    int b;
    for (int k = 0; k < N; k++) exp_rows[k] = wt[k*N*16 +: N*16];
    exp_acc++;
    for (int k = 0; k < N; k++) begin
      w_valid = 1'b1; w_data = wt[k*N*16 +: N*16];
      b = 0;
      while (!w_ready && b < 50) begin tick(); b++; end
      if (!w_ready) chk("w_ready_timeout", 0, 1);
      tick();
      $display("weight beat %0d row %h", k, wt[k*N*16 +: N*16]);
      w_valid = 1'b0; w_data = '0;
      if (gaps) tick();
    end
  endtask

  task automatic send_vec(input logic [N*16-1:0] v, input logic [N*32-1:0] e);
    exp_t it;
    int b;
    a_valid = 1'b1; a_data = v;
    b = 0;
    while (!a_ready && b < 50) begin tick(); b++; end
    if (!a_ready) chk("a_ready_timeout", 0, 1);
    last_acc_t = cyc;
    it.data = e; it.cyc = cyc + 2*N + 1;
    sb_q.push_back(it);
    tick();
    $display("vector accepted cycle %0d data %h", last_acc_t, v);
    a_valid = 1'b0; a_data = '0;
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    @(negedge clk);
    while (!done && b < 200) begin @(negedge clk); b++; end
    if (!done) begin
      chk("done_timeout", 0, 1);
    end else begin
      $display("done cycle %0d", cyc);
      chk("done_cycle", cyc, last_res_cyc + 1);
      chk("busy_at_done", {busy, arr_enabled}, 2'b00);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end
    chk("sb_empty", sb_q.size(), 0);
    tick();
  endtask

  function automatic logic [N*N*16-1:0] ident();
    logic [N*N*16-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[(k*N + k)*16 +: 16] = 16'd1;
    return v;
  endfunction

  function automatic logic [N*N*16-1:0] ramp();
    logic [N*N*16-1:0] v;
    for (int k = 0; k < N; k++)
      for (int c = 0; c < N; c++) v[(k*N + c)*16 +: 16] = 16'(4*k + c + 1);
    return v;
  endfunction

  logic [N*16-1:0] vv;
  logic [N*32-1:0] ee;
  logic            seen;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_mode = '0; cfg_num_vec = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    for (int k = 0; k < N; k++) begin wh[k] = '0; exp_rows[k] = '0; sw_cnt[k] = 0; sw_cyc[k] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {busy, done, w_ready, a_ready, arr_enabled, arr_mode, arr_accept_w, arr_valid, arr_switch, res_valid}, 0);
    chk("rst_data", {arr_weight, arr_input}, 0);
    chk("rst_res", res_data, 0);
    tick();
    rst = 1'b0;
    tick();

    // Identity weights, one vector (INT16)
    acc_pulses = 0;
    start_job(2'b01, 1);
    load_w(ident(), 1'b0);
    send_vec({16'd4, 16'd3, 16'd2, 16'd1}, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_done();
    chk("t1_accept_pulses", acc_pulses, 1);
    chk("t1_mode", arr_mode, 2'b01);

    // Toggling w_valid, asymmetric weights
    start_job(2'b01, 2);
    load_w(ramp(), 1'b1);
    send_vec({16'd4, 16'd3, 16'd2, 16'd1}, {32'd120, 32'd110, 32'd100, 32'd90});
    send_vec({16'd0, 16'd0, 16'd0, 16'd1}, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_done();

    // Five vectors with a two-cycle bubble after the second
    for (int k = 0; k < N; k++) sw_cnt[k] = 0;
    start_job(2'b01, 5);
    load_w(ident(), 1'b0);
    for (int i = 0; i < 5; i++) begin
      for (int r = 0; r < N; r++) begin
        vv[r*16 +: 16] = 16'(16*r + i + 1);
        ee[r*32 +: 32] = 32'(16*r + i + 1);
      end
      send_vec(vv, ee);
      if (i == 0) first_acc_t = last_acc_t;
      if (i == 1) begin tick(); tick(); end
    end
    wait_done();
    for (int r = 0; r < N; r++) begin
      chk("switch_count", sw_cnt[r], 1);
      chk("switch_skew", sw_cyc[r], first_acc_t + 1 + r);
    end

    // INT4x4 mode
    start_job(2'b11, 1);
    load_w({(N*N){16'h1111}}, 1'b0);
    send_vec({N{16'h1111}}, {N{32'd16}});
    wait_done();
    repeat (3) tick();
    chk("mode_hold", arr_mode, 2'b11);

    // Zero-length job
    start_job(2'b10, 0);
    chk("nv0_done", {done, busy, arr_enabled}, 3'b100);
    chk("nv0_mode", arr_mode, 2'b10);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen = seen | w_ready | arr_enabled | done; end
    chk("nv0_quiet", seen, 0);

    // cfg_start while busy is ignored
    start_job(2'b01, 2);
    cfg_start = 1'b1; cfg_mode = 2'b00; cfg_num_vec = CW'(7);
    tick();
    cfg_start = 1'b0;
    chk("busy_start_mode", arr_mode, 2'b01);
    load_w(ident(), 1'b0);
    send_vec({16'd8, 16'd7, 16'd6, 16'd5}, {32'd8, 32'd7, 32'd6, 32'd5});
    send_vec({16'd1, 16'd1, 16'd1, 16'd1}, {32'd1, 32'd1, 32'd1, 32'd1});
    wait_done();

    // Reset mid-stream after three acceptances
    start_job(2'b01, 8);
    load_w(ident(), 1'b0);
    for (int i = 0; i < 3; i++) send_vec({N{16'(i + 1)}}, {N{32'(i + 1)}});
    rst = 1'b1;
    tick();
    sb_q.delete();
    $display("reset asserted mid-stream cycle %0d", cyc);
    chk("midrst_ctrl", {busy, done, w_ready, a_ready, arr_enabled, arr_mode, arr_accept_w, arr_valid, arr_switch, res_valid}, 0);
    chk("midrst_data", {arr_weight, arr_input}, 0);
    tick(); tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin tick(); seen = seen | done | res_valid | busy; end
    chk("midrst_quiet", seen, 0);

    start_job(2'b01, 1);
    load_w(ident(), 1'b0);
    send_vec({16'd4, 16'd3, 16'd2, 16'd1}, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_done();

    chk("accept_pulse_total", acc_pulses, exp_acc);
    chk("accept_switch_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
